// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler that owns HI/LO beside the E-stage ALU.
// Divider support is compiled in only when MD_SCHED_DIV_EN is defined.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbg_state
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi, r_lo, r_phi, r_plo;
    logic          r_busy, r_done;

    logic [63:0]   w_ma, w_mb, w_prod;
    logic          w_is_md;
    logic [CW-1:0] w_lat;
    logic [31:0]   w_nhi, w_nlo;

    // One 64-bit multiplier serves both flavours: the low 64 bits of a
    // product are identical for signed and unsigned once operands are extended.
    assign w_ma   = {{32{(op == OP_MULT) & A[31]}}, A};
    assign w_mb   = {{32{(op == OP_MULT) & B[31]}}, B};
    assign w_prod = w_ma * w_mb;

`ifdef MD_SCHED_DIV_EN
    localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);
    localparam logic [2:0]    OP_DIV  = 3'd2;

    logic        w_sdiv, w_bz;
    logic [31:0] w_da, w_db, w_uq, w_ur, w_q, w_r;

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    assign w_sdiv = (op == OP_DIV);
    assign w_bz   = (B == 32'd0);
    assign w_da   = (w_sdiv && A[31]) ? (~A + 32'd1) : A;
    assign w_db   = (w_sdiv && B[31]) ? (~B + 32'd1) : B;
    assign w_uq   = w_bz ? 32'd0 : (w_da / w_db);
    assign w_ur   = w_bz ? 32'd0 : (w_da % w_db);
    assign w_q    = (w_sdiv && (A[31] ^ B[31])) ? (~w_uq + 32'd1) : w_uq;
    assign w_r    = (w_sdiv && A[31]) ? (~w_ur + 32'd1) : w_ur;
    assign w_is_md = (op[2:1] == 2'b00) || (op[2:1] == 2'b01);
`else
    assign w_is_md = (op == OP_MULT) || (op == OP_MULTU);
`endif

    always_comb begin
        w_lat = MULT_LAT;
        w_nhi = w_prod[63:32];
        w_nlo = w_prod[31:0];
`ifdef MD_SCHED_DIV_EN
        if (op[2:1] == 2'b01) begin
            w_lat = DIV_LAT;
            // Divide by zero commits the current HI/LO, i.e. leaves them alone.
            w_nhi = w_bz ? r_hi : w_r;
            w_nlo = w_bz ? r_lo : w_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_md) begin
                            r_phi   <= w_nhi;
                            r_plo   <= w_nlo;
                            r_cnt   <= w_lat;
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end else if (op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (op == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= r_phi;
                        r_lo    <= r_plo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = (r_state == ST_RUN);
endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: known-answer table, corner sequences and
// randomized traffic against a transaction-level HI/LO model.
module tb_md_sched;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MD_SCHED_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, dbg_state;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO plus the edge number at which the
    // in-flight operation commits.
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_run = 0, m_done = 0;
    int          cyc = 0, m_end = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                       output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p, q, r;
        longint unsigned ux, uy, up, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        rh = m_hi;
        rl = m_lo;
        case (o)
            3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
            3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; rh = r[31:0]; rl = q[31:0]; end
            3'd3: if (y != 0) begin uq = ux / uy; ur = ux % uy; rh = ur[31:0]; rl = uq[31:0]; end
            default: ;
        endcase
    endfunction

    function automatic void model_edge();
        cyc++;
        m_done = 0;
        if (!reset_n) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_run = 0;
        end else if (m_run) begin
            if (cyc == m_end) begin
                m_hi = m_phi; m_lo = m_plo; m_run = 0; m_done = 1;
                exp_q.push_back({m_hi, m_lo});
            end
        end else if (start) begin
            if (op < 3'd2 || (DIV_ON && op < 3'd4)) begin
                ref_result(op, a, b, m_phi, m_plo);
                m_run = 1;
                m_end = cyc + ((op < 3'd2) ? MULT_N : DIV_N);
            end else if (op == 3'd4) begin
                m_hi = a;
            end else if (op == 3'd5) begin
                m_lo = a;
            end
        end
    endfunction

    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        model_edge();
        #1;
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("dbg_state", 32'(dbg_state), 32'(m_run));
        if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_hi", hi, e[63:32]);
            check("sb_lo", lo, e[31:0]);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    // Issues one op and waits (bounded) for done, scrambling A/B meanwhile.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int bc);
        bit got;
        got = 0;
        issue(o, x, y);
        bc = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < DIV_N + 5 && !got; i++) begin
            a = $urandom; b = $urandom;
            tick();
            if (busy === 1'b1) bc++;
            if (done === 1'b1) got = 1;
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        bit saw_done;
        vecs.push_back('{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N});
        vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MULT_N});
        vecs.push_back('{3'd0, 32'd3, 32'd4, 32'd0, 32'd12, MULT_N});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N});
        vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N});
`ifdef MD_SCHED_DIV_EN
        vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_N});
        vecs.push_back('{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_N});
        vecs.push_back('{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_N});
`endif

        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // MTHI then a two-cycle reset clears HI/LO.
        issue(3'd4, 32'h1234, 32'd0);
        check("mthi", hi, 32'h1234);
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst2_hi", hi, 32'd0);
        check("rst2_lo", lo, 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
            check($sformatf("vec%0d_lat", i), bc, vecs[i].lat);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // MTHI during RUN is dropped; a start in the done cycle is accepted.
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        issue(3'd0, 32'd3, 32'd4);
        issue(3'd4, 32'hAAAA, 32'd0);
        saw_done = 0;
        for (int i = 0; i < MULT_N + 3 && !saw_done; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        check("run_ign_done", 32'(saw_done), 32'd1);
        check("run_ign_hi", hi, 32'd0);
        check("run_ign_lo", lo, 32'd12);
        issue(3'd1, 32'd7, 32'd6);
        check("b2b_busy", 32'(busy), 32'd1);
        for (int i = 0; i < MULT_N; i++) tick();
        check("b2b_lo", lo, 32'd42);

        // Reset in the third busy cycle aborts without a commit.
        issue(3'd0, 32'd5, 32'd5);
        tick(); tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_lo", lo, 32'd0);
        saw_done = 0;
        for (int i = 0; i < MULT_N + 2; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_lo2", lo, 32'd0);

`ifdef MD_SCHED_DIV_EN
        issue(3'd5, 32'h55, 32'd0);
        run_op(3'd3, 32'd9, 32'd0, bc);
        check("div0_lat", bc, DIV_N);
        check("div0_lo", lo, 32'h55);
        check("div0_hi", hi, 32'd0);
`else
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd2, 32'd10, 32'd2);
        check("nodiv_busy", 32'(busy), 32'd0);
        tick(); tick();
        check("nodiv_hi", hi, 32'h11);
        check("nodiv_lo", lo, 32'h22);
`endif

        for (int i = 0; i < 500; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 2) == 0);
            op      = 3'($urandom_range(0, 7));
            a       = rand_word();
            b       = rand_word();
            tick();
        end
        reset_n = 1'b1; start = 1'b0;
        for (int i = 0; i < DIV_N + 3; i++) tick();
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_sched.md
# md_sched

Multi-cycle multiply/divide scheduler for the MIPS pipeline's E stage. It sits beside the single-cycle ALU and owns the HI/LO registers. It accepts one mult/div/mthi/mtlo request per start pulse and holds `busy` for the operation latency so hazard logic can stall later HI/LO instructions. HI/LO update atomically when the operation completes.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; must be ≥1.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `start` in 1: request strobe, sampled every edge.
- `op` in 3: request type. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
- `A` in 32: rs operand.
- `B` in 32: rt operand.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse in the first cycle new HI/LO are visible.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- Two-state FSM: IDLE and RUN. A down-counter `cnt` covers `max(MULT_CYCLES, DIV_CYCLES)`.
- **IDLE with `start`=1:**
  - op 0/1/2/3: capture the result into internal pending registers `phi`/`plo`. Load `cnt` with the op latency, go to RUN, and set `busy`=1.
  - op 4 (MTHI): `hi`←A at this edge. No busy, no done.
  - op 5 (MTLO): `lo`←A at this edge. No busy, no done.
  - op 6/7: ignored, no state change.
- **RUN:** decrement `cnt` each edge. On the edge where `cnt`=1:
  - `hi`←`phi`, `lo`←`plo`.
  - Go to IDLE, `busy`←0, `done`←1.
- **`start` while in RUN:** ignored completely, including MTHI/MTLO. Hazard logic must not issue in this case. The bench checks that nothing changes.
- **Arithmetic:**
  - MULT: 64-bit signed product; `hi`=[63:32], `lo`=[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed. `lo`=quotient, truncated toward zero. `hi`=remainder, with the sign of the dividend A.
  - DIV overflow, A=0x80000000 and B=0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B=0, DIV or DIVU): the op still runs the full DIV_CYCLES, then leaves `hi`/`lo` unchanged. `done` still pulses.
- `hi`/`lo` keep their old values throughout RUN. Readers (mfhi/mflo) must be stalled by hazard logic while `busy`.

## Timing
- **Reset:** while `reset_n`=0 at an edge, the state goes to IDLE. After that edge:
  - `busy`=0, `done`=0, `cnt`=0.
  - `hi`=0, `lo`=0, `phi`=0, `plo`=0.
- **Reset mid-RUN:** aborts the operation. No HI/LO commit occurs.
- **Mult/div latency:** with `start` sampled at edge k and latency N:
  - `busy`=1 in cycles k+1 … k+N.
  - `hi`/`lo` hold new values from cycle k+N+1; `done`=1 in cycle k+N+1 only.
- **Back-to-back:** a new `start` is accepted at edge k+N+1 (the `done` cycle is IDLE). The next op is therefore never lost and its results do not overlap.
- **MTHI/MTLO latency:** `start` at edge k makes the new value visible in cycle k+1.
- **Operand capture:** `A`/`B` are sampled only at the start edge. Later changes have no effect.

## Configuration
- Macro `MD_SCHED_DIV_EN`.
- Defined: DIV/DIVU are implemented as above.
- Undefined:
  - op 2/3 are treated as reserved and ignored: no busy, no done, no change.
  - No divider logic is synthesized.
  - `DIV_CYCLES` is unused.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles after MTHI 0x1234 -> `hi`=0, `lo`=0, `busy`=0.
- **MULT:** A=0xFFFFFFFE (−2), B=3 -> `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA with a one-cycle `done`. MULTU of the same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- **DIV:** A=−7 (0xFFFFFFF9), B=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 busy cycles. DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. DIVU by 0 after MTLO 0x55 -> `lo` stays 0x55.
- **Ignored during RUN:** MTHI 0xAAAA issued during RUN of a MULT 3×4 -> ignored. Final `hi`=0, `lo`=12. A MULTU start in the `done` cycle is accepted, and `busy` rises the next cycle.
- **Abort:** reset asserted in the 3rd busy cycle of MULT 5×5 -> `busy`=0 and `lo`=0 afterwards, with no `done` pulse.
- **Macro off:** with `MD_SCHED_DIV_EN` undefined, DIV 10/2 -> `busy` stays 0 and `hi`/`lo` are unchanged.
